carry_select_serial_adder: RTL
==============================

// Module: carry_select_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder. Streams operands 4 bits per cycle through a single
//  carry_select_adder_4bit_slice instance, least-significant nibble first.
//  Registers the slice carry-out and feeds it back as the next nibble's c_in.
//  Area-lean alternative to a fully unrolled carry-select chain; sits between the
//  operand source and the result consumer under a start/done handshake.
// PARAMETERS
//  WIDTH  16  operand/result width; multiple of 4, >= 8 (elaboration error otherwise)
//  (localparam NSLICE = WIDTH/4 = slice iterations per add; counter width $clog2(NSLICE))
// PORTS
//  clk    in   1      clock; all state updates on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only when busy=0
//  a      in   WIDTH  operand A; sampled with accepted start
//  b      in   WIDTH  operand B; sampled with accepted start
//  c_in   in   1      carry-in; sampled with accepted start
//  busy   out  1      1 while an add is in progress (state RUN)
//  done   out  1      1-cycle pulse; s and c are valid from this cycle
//  s      out  WIDTH  registered sum; holds last result until next completion
//  c      out  1      registered carry-out of the MSB nibble; holds like s
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, s=0, c=0, nibble counter=0, shift regs=0.
//   rst has priority over every event in the same cycle.
//  States:
//   IDLE - start=1 -> latch a,b into shift regs, carry_q<=c_in, cnt<=0; go RUN.
//   RUN  - each edge: slice adds low nibble of a_sh,b_sh with sel=carry_q.
//          Slice sum enters the top nibble of sum_sh (shift right 4); carry_q<=slice c.
//          a_sh,b_sh shift right 4; cnt++.
//          At cnt==NSLICE-1: s<=final sum, c<=slice c; go DONE.
//          start ignored in RUN.
//   DONE - done=1 for this cycle only. start=1 -> accept as in IDLE, go RUN
//          (back-to-back; no idle bubble). Else -> IDLE.
//  busy = (state==RUN); done = (state==DONE); both registered-state decodes.
//  Latency: start sampled at edge E -> done=1 in the cycle after edge E+NSLICE.
//   Throughput: one add per NSLICE+1 cycles.
//  Arithmetic: {c,s} == a + b + c_in, modulo 2^(WIDTH+1); unsigned; no overflow flag.
//  s/c unchanged during RUN; only the final edge updates them, never partial values.
//  Boundaries:
//   - carry ripples across all nibbles through carry_q (e.g. all-ones + 1)
//   - rst mid-RUN aborts: no done pulse; s/c return to 0
//   - start held high continuously -> one add per NSLICE+1 cycles
//   - a/b/c_in changes while busy have no effect
// CONFIGURATION
//  CSEL_SUB_EN defined: adds port  sub  in  1, sampled with accepted start.
//   sub=1: b latched as ~b, carry_q initialised to 1 (c_in ignored).
//   Result: s = a - b mod 2^WIDTH, c = 1 when no borrow (a >= b unsigned).
//   sub=0: identical to the base add.
//  CSEL_SUB_EN undefined: no sub port; always adds.
// TESTING (WIDTH=16, NSLICE=4)
//  1. a=16'h1234, b=16'h4321, c_in=0, start -> busy 4 cycles, done pulse;
//     s=16'h5555, c=0.
//  2. a=16'hFFFF, b=16'h0001, c_in=0 -> s=16'h0000, c=1 (full ripple);
//     a=b=16'hFFFF, c_in=1 -> s=16'hFFFF, c=1.
//  3. start pulsed during RUN, operands changed -> ignored, first result intact;
//     start=1 in DONE cycle -> second done exactly 5 cycles after first.
//  4. rst asserted at 2nd RUN cycle -> next cycle busy=0, done=0, s=0, c=0;
//     no done pulse follows.
//  5. CSEL_SUB_EN, sub=1: a=5, b=7 -> s=16'hFFFE, c=0; a=7, b=5 -> s=16'h0002, c=1.
//  6. 10k random a, b, c_in (random start gaps) vs reference model a+b+c_in;
//     check {c,s} and done count == accepted start count.

Source files
------------

// File: rtl/carry_select_serial_adder_if.sv
// Start/done handshake bundle for the nibble-serial adder.
// CSEL_SUB_EN adds the sub request bit.
interface carry_select_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef CSEL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c;

`ifdef CSEL_SUB_EN
  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, s, c
  );
  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, s, c
  );
`else
  modport master (
    output start, a, b, c_in,
    input  busy, done, s, c
  );
  modport slave (
    input  start, a, b, c_in,
    output busy, done, s, c
  );
`endif
endinterface

// File: rtl/carry_select_serial_adder.sv
// Multi-cycle adder: one 4-bit carry-select slice reused per nibble, LSB first.
// Define CSEL_SUB_EN to enable subtraction via bus.sub.
module carry_select_adder_4bit_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sel,
  output logic [3:0] s,
  output logic       c
);
  logic [4:0] r0;
  logic [4:0] r1;

  // both carry hypotheses computed, carry-in only picks one
  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + 5'd1;
  assign {c, s} = sel ? r1 : r0;
endmodule

module carry_select_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  carry_select_serial_adder_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-5:0] sum_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] s_q;
  logic             c_q;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_in;
  logic             cin_eff;
  logic [3:0]       sl_s;
  logic             sl_c;
  logic [WIDTH-1:0] sum_nxt;

  assign accept = bus.start && (state != RUN);
  assign last = (cnt == CW'(NSLICE - 1));

`ifdef CSEL_SUB_EN
  // a - b computed as a + ~b + 1; carry-out is the not-borrow flag
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1 : bus.c_in;
`else
  assign b_in = bus.b;
  assign cin_eff = bus.c_in;
`endif

  carry_select_adder_4bit_slice u_slice (
    .a   (a_sh[3:0]),
    .b   (b_sh[3:0]),
    .sel (carry_q),
    .s   (sl_s),
    .c   (sl_c)
  );

  assign sum_nxt = {sl_s, sum_sh};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else if (accept) begin
      a_sh    <= bus.a;
      b_sh    <= b_in;
      carry_q <= cin_eff;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 4;
      b_sh    <= b_sh >> 4;
      sum_sh  <= sum_nxt[WIDTH-1:4];
      carry_q <= sl_c;
      cnt     <= cnt + 1'b1;
      if (last) begin
        s_q <= sum_nxt;
        c_q <= sl_c;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.s    = s_q;
  assign bus.c    = c_q;
endmodule
